// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment display scanner with double-buffered digit data.
// Define SEG_DISPLAY_BLINK_EN to enable per-digit blinking via blink_mask.
module seg_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    seg_a,
  output logic                    seg_b,
  output logic                    seg_c,
  output logic                    seg_d,
  output logic                    seg_e,
  output logic                    seg_f,
  output logic                    seg_g,
  output logic                    seg_p,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_nd
    $error("NUM_DIGITS out of range");
  end
  if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_sd
    $error("SCAN_DIV out of range");
  end
  if (BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_bad_bd
    $error("BLINK_DIV out of range");
  end

  logic [SW-1:0] r_slot;
  logic [IW-1:0] r_idx;
  logic          r_pflag;

  logic [NUM_DIGITS-1:0][3:0] r_pend_data;
  logic [NUM_DIGITS-1:0]      r_pend_blank;
  logic [NUM_DIGITS-1:0]      r_pend_blink;
  logic [NUM_DIGITS-1:0]      r_pend_dp;

  logic [NUM_DIGITS-1:0][3:0] r_act_data;
  logic [NUM_DIGITS-1:0]      r_act_blank;
  logic [NUM_DIGITS-1:0]      r_act_blink;
  logic [NUM_DIGITS-1:0]      r_act_dp;

  logic [6:0]            r_seg;
  logic                  r_segp;
  logic [NUM_DIGITS-1:0] r_den;
  logic                  r_fdone;

  logic       w_slot_end;
  logic       w_bnd;
  logic       w_phase;
  logic       w_dark;
  logic [3:0] w_nib;
  logic [6:0] w_dec;

  assign w_slot_end = (r_slot == SLOT_LAST);
  assign w_bnd      = w_slot_end && (r_idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (w_slot_end) begin
      r_slot <= '0;
      r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  // Pending set absorbs loads; active set only changes at frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pflag      <= 1'b0;
      r_pend_data  <= '0;
      r_pend_blank <= '0;
      r_pend_blink <= '0;
      r_pend_dp    <= '0;
      r_act_data   <= '0;
      r_act_blank  <= '0;
      r_act_blink  <= '0;
      r_act_dp     <= '0;
    end else begin
      if (load) begin
        r_pend_data  <= digit_data;
        r_pend_blank <= blank_mask;
        r_pend_blink <= blink_mask;
        r_pend_dp    <= dp_mask;
      end
      if (w_bnd) begin
        r_pflag <= 1'b0;
        if (load) begin
          r_act_data  <= digit_data;
          r_act_blank <= blank_mask;
          r_act_blink <= blink_mask;
          r_act_dp    <= dp_mask;
        end else if (r_pflag) begin
          r_act_data  <= r_pend_data;
          r_act_blank <= r_pend_blank;
          r_act_blink <= r_pend_blink;
          r_act_dp    <= r_pend_dp;
        end
      end else if (load) begin
        r_pflag <= 1'b1;
      end
    end
  end

`ifdef SEG_DISPLAY_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

  logic [FW-1:0] r_fcnt;
  logic          r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_bnd) begin
      if (r_fcnt == FCNT_LAST) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_phase = r_phase;
`else
  assign w_phase = 1'b0;
`endif

  assign w_nib  = r_act_data[r_idx];
  assign w_dark = r_act_blank[r_idx] |
                  (r_act_blink[r_idx] & w_phase);

  // Active-low {g,f,e,d,c,b,a}
  always_comb begin
    w_dec = 7'h7F;
    unique case (w_nib)
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h10;
      4'hA: w_dec = 7'h08;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      4'hF: w_dec = 7'h0E;
    endcase
  end

  // Slot count 0 is dead time: no digit selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg   <= 7'h7F;
      r_segp  <= 1'b1;
      r_den   <= '1;
      r_fdone <= 1'b0;
    end else begin
      r_seg   <= w_dark ? 7'h7F : w_dec;
      r_segp  <= ~(r_act_dp[r_idx] & ~w_dark);
      r_den   <= (r_slot == '0) ? '1 :
                 ~(NUM_DIGITS'(1) << r_idx);
      r_fdone <= w_bnd;
    end
  end

  assign seg_a      = r_seg[0];
  assign seg_b      = r_seg[1];
  assign seg_c      = r_seg[2];
  assign seg_d      = r_seg[3];
  assign seg_e      = r_seg[4];
  assign seg_f      = r_seg[5];
  assign seg_g      = r_seg[6];
  assign seg_p      = r_segp;
  assign digit_en   = r_den;
  assign frame_done = r_fdone;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed table-driven bench for seg_display_scanner
// (NUM_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2).
module tb_seg_display_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic        seg_a, seg_b, seg_c, seg_d;
  logic        seg_e, seg_f, seg_g, seg_p;
  logic [3:0]  digit_en;
  logic        frame_done;

  int n_pass  = 0;
  int n_total = 0;

`ifdef SEG_DISPLAY_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  seg_display_scanner #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (4),
    .BLINK_DIV (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .digit_data(digit_data),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .dp_mask   (dp_mask),
    .seg_a     (seg_a),
    .seg_b     (seg_b),
    .seg_c     (seg_c),
    .seg_d     (seg_d),
    .seg_e     (seg_e),
    .seg_f     (seg_f),
    .seg_g     (seg_g),
    .seg_p     (seg_p),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [27:0] segs;
    logic [3:0]  p;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [12:0] obs();
    return {frame_done, digit_en, seg_p,
            seg_g, seg_f, seg_e, seg_d,
            seg_c, seg_b, seg_a};
  endfunction

  task automatic chk(input string nm,
                     input logic [12:0] act,
                     input logic [12:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic do_load(input logic [15:0] d,
                         input logic [3:0] bl,
                         input logic [3:0] bk,
                         input logic [3:0] dp);
    @(negedge clk);
    digit_data = d;
    blank_mask = bl;
    blink_mask = bk;
    dp_mask    = dp;
    load       = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    for (int i = 0; i < 40 && !frame_done; i++)
      @(negedge clk);
    n_total++;
    if (frame_done) n_pass++;
    else $display("FAIL %s: frame_done got 0 expected 1", nm);
  endtask

  // Checks one full frame; optionally loads ld_d at cycle ld_c.
  task automatic check_frame(input string nm,
                             input logic [27:0] segs,
                             input logic [3:0] p,
                             input int ld_c,
                             input logic [15:0] ld_d);
    for (int c = 0; c < 16; c++) begin
      int d;
      logic [3:0]  sel;
      logic [12:0] exp;
      d = c / 4;
      sel = 4'b0001 << d;
      @(negedge clk);
      exp[12]   = (c == 15);
      exp[11:8] = (c % 4 == 0) ? 4'hF : ~sel;
      exp[7]    = p[d];
      exp[6:0]  = segs[7*d +: 7];
      chk($sformatf("%s c%0d", nm, c), obs(), exp);
      load = 1'b0;
      if (c == ld_c) begin
        digit_data = ld_d;
        blank_mask = 4'h0;
        blink_mask = 4'h0;
        dp_mask    = 4'h0;
        load       = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    logic [27:0] lit, drk;
    bit dark;

    vecs[0] = '{"hex3210", 16'h3210, 4'h0, 4'h0,
      {7'h30, 7'h24, 7'h79, 7'h40}, 4'hF};
    vecs[1] = '{"hex7654", 16'h7654, 4'h0, 4'h0,
      {7'h78, 7'h02, 7'h12, 7'h19}, 4'hF};
    vecs[2] = '{"hexBA98", 16'hBA98, 4'h0, 4'h0,
      {7'h03, 7'h08, 7'h10, 7'h00}, 4'hF};
    vecs[3] = '{"hexFEDC", 16'hFEDC, 4'h0, 4'h0,
      {7'h0E, 7'h06, 7'h21, 7'h46}, 4'hF};
    vecs[4] = '{"blank_dp", 16'h3210, 4'b0010, 4'b0001,
      {7'h30, 7'h24, 7'h7F, 7'h40}, 4'b1110};
    vecs[5] = '{"dp_all", 16'h5A0F, 4'b1000, 4'b1111,
      {7'h7F, 7'h08, 7'h40, 7'h0E}, 4'b1000};

    reset      = 1'b1;
    load       = 1'b0;
    digit_data = '0;
    blank_mask = '0;
    blink_mask = '0;
    dp_mask    = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", obs(), 13'h0FFF);

    // Blink sequence from a clean frame/phase count
    reset      = 1'b0;
    digit_data = 16'h3210;
    blink_mask = 4'b0100;
    load       = 1'b1;
    check_frame("blink_f0", {4{7'h40}}, 4'hF, -1, 16'h0);
    lit = {7'h30, 7'h24, 7'h79, 7'h40};
    drk = {7'h30, 7'h7F, 7'h79, 7'h40};
    for (int f = 1; f <= 6; f++) begin
      dark = BLINK && (f == 2 || f == 3 || f == 6);
      check_frame($sformatf("blink_f%0d", f),
                  dark ? drk : lit, 4'hF, -1, 16'h0);
    end

    for (int v = 0; v < 6; v++) begin
      do_load(vecs[v].data, vecs[v].blank, 4'h0, vecs[v].dp);
      wait_frame(vecs[v].name);
      check_frame(vecs[v].name, vecs[v].segs, vecs[v].p,
                  -1, 16'h0);
    end

    // Mid-frame load must not disturb the current frame
    do_load(16'h3210, 4'h0, 4'h0, 4'h0);
    wait_frame("pre_mid");
    check_frame("mid_old", vecs[0].segs, 4'hF, 5, 16'hFFFF);
    // Load on the boundary cycle goes straight to active
    check_frame("mid_new", {4{7'h0E}}, 4'hF, 14, 16'h0008);
    check_frame("bnd_new", {7'h40, 7'h40, 7'h40, 7'h00},
                4'hF, -1, 16'h0);

    // Reset mid-slot at digit 2, with a concurrent load
    repeat (10) @(negedge clk);
    reset      = 1'b1;
    digit_data = 16'hFFFF;
    dp_mask    = 4'hF;
    load       = 1'b1;
    @(negedge clk);
    chk("rst_mid_1", obs(), 13'h0FFF);
    @(negedge clk);
    chk("rst_mid_2", obs(), 13'h0FFF);
    reset = 1'b0;
    load  = 1'b0;
    check_frame("post_rst_f0", {4{7'h40}}, 4'hF, -1, 16'h0);
    check_frame("post_rst_f1", {4{7'h40}}, 4'hF, -1, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal 2..2^20).
REQ-003 SHALL have parameter BLINK_DIV, default 64, frames per blink half-period (legal 1..255).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port load, input, 1, one-cycle strobe that captures all data/mask inputs.
REQ-007 SHALL have port digit_data, input, 4*NUM_DIGITS, hex nibble per digit; digit i in bits [4i+3:4i].
REQ-008 SHALL have port blank_mask, input, NUM_DIGITS, 1 = digit i dark.
REQ-009 SHALL have port blink_mask, input, NUM_DIGITS, 1 = digit i blinks.
REQ-010 SHALL have port dp_mask, input, NUM_DIGITS, 1 = decimal point of digit i lit.
REQ-011 SHALL have port seg_a..seg_g, output, 1 each, active-low segments.
REQ-012 SHALL have port seg_p, output, 1, active-low decimal point.
REQ-013 SHALL have port digit_en, output, NUM_DIGITS, active-low digit select, one-hot-low or all high.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at end of each full scan.

Function
REQ-015 SHALL hold a pending register set (data, blank, blink, dp) written on every cycle load=1; latest load wins.
REQ-016 SHALL copy pending to the active set at the frame boundary (slot counter at SCAN_DIV-1 and digit index at NUM_DIGITS-1), only when a load occurred since the last copy; active data never changes mid-frame.
REQ-017 SHALL, when load coincides with the frame-boundary cycle, copy the newly loaded inputs directly to the active set at that boundary.
REQ-018 SHALL count the slot counter 0..SCAN_DIV-1, then wrap to 0 and advance the digit index 0..NUM_DIGITS-1, wrapping to 0.
REQ-019 SHALL pulse frame_done for exactly the cycle after the frame boundary (registered).
REQ-020 SHALL register all segment and digit_en outputs; they reflect the digit index with one cycle latency.
REQ-021 SHALL drive digit_en all-high during slot count 0 of every slot (dead time); otherwise drive only bit [index] low.
REQ-022 SHALL decode nibbles active-low, {g,f,e,d,c,b,a} hex: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-023 SHALL force all seven segments and seg_p high for a digit whose active blank bit is 1, or whose blink bit is 1 while blink phase is 1.
REQ-024 SHALL drive seg_p low when the digit's dp bit is 1 and the digit is not dark.
REQ-025 SHALL count frames 0..BLINK_DIV-1 and toggle blink phase on wrap.

Reset
REQ-026 SHALL on reset=1 clear slot counter, digit index, frame counter, blink phase, pending flag and active/pending sets to 0.
REQ-027 SHALL on reset drive seg_a..seg_g=1, seg_p=1, digit_en all 1, frame_done=0, from the next edge; a load concurrent with reset is discarded.
REQ-028 SHALL restart scanning at digit 0, slot 0 on the first cycle after reset deasserts.

Configuration
REQ-029 SHALL, with macro SEG_DISPLAY_BLINK_EN defined, implement the frame counter, blink phase and blink_mask behaviour of REQ-023/025.
REQ-030 SHALL, without SEG_DISPLAY_BLINK_EN, omit blink logic, ignore blink_mask and treat blink phase as constant 0.

Verification
REQ-031 SHALL test NUM_DIGITS=4, SCAN_DIV=4: load data=16'h3210 -> after boundary, digit_en cycles E,D,B,7 with segs 40,79,24,30; digit_en=F on each slot's first cycle.
REQ-032 SHALL test load mid-frame with 16'hFFFF -> old digits complete current frame; 0E shown only after frame_done.
REQ-033 SHALL test load on boundary cycle with 16'h0008 -> digit 0 shows 00 in immediately following frame.
REQ-034 SHALL test blank_mask=4'b0010, dp_mask=4'b0001 -> digit 1 all segs and seg_p high; digit 0 seg_p low.
REQ-035 SHALL test BLINK_DIV=2, blink_mask=4'b0100, SEG_DISPLAY_BLINK_EN defined -> digit 2 lit 2 frames, dark 2 frames; undefined -> always lit.
REQ-036 SHALL test reset asserted mid-slot at digit 2 -> next cycle outputs all 1, frame_done 0; scan resumes at digit 0, active data 0.
